axis_length_split_pro: RTL and testbench

Parametrised AXI-Stream fragmenter. It cuts each incoming packet into fragments of at most `length` beats by forcing tlast, and adds fragment-boundary sideband flags. The requested length is latched once per input packet, so changing `length` mid-packet is safe. The output is registered through a full-throughput skid slice. It sits in front of DMA/packet engines that need bounded burst lengths.

---
 rtl/axis_length_split_pro_pkg.sv | 10 +
 rtl/axis_length_split_pro_if.sv | 16 +
 rtl/axis_length_split_pro_skid.sv | 74 +++++++
 rtl/axis_length_split_pro.sv | 144 ++++++++++++++
 tb/tb_axis_length_split_pro.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_length_split_pro_pkg.sv
// axis_split_pkg: shared constants for the AXI-Stream length splitter.
// split_beat_t depends on the module's width parameters. A package cannot take
// parameters, so that struct is declared inside axis_length_split_pro with the
// field order {tdata, tkeep, tuser, tlast, frag_first, pkt_last, frag_idx}.
package axis_split_pkg;

    // A requested length of LEN_PASS means "do not split".
    localparam int LEN_PASS = 0;

endpackage

// File: rtl/axis_length_split_pro_if.sv
// axis_length_split_pro_if: plain AXI-Stream bundle with master/slave modports.
interface axis_length_split_pro_if #(
    parameter int DSIZE = 32,
    parameter int KSIZE = DSIZE/8,
    parameter int USIZE = 1
);
    logic             tvalid;
    logic             tready;
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic [USIZE-1:0] tuser;
    logic             tlast;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/axis_length_split_pro_skid.sv
// axis_skid_slice: 2-entry valid/ready register slice for a W-bit payload.
// in_ready is a register (true when the skid entry is empty), so there is no
// combinational path from out_ready back to in_ready. Full rate with out_ready=1.
module axis_skid_slice #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         out_valid_r, out_valid_s;
    logic         skid_valid_r, skid_valid_s;
    logic         ready_r, ready_s;
    logic [W-1:0] out_data_r, out_data_s;
    logic [W-1:0] skid_data_r, skid_data_s;
    logic         in_acc_s;

    // Next-state for the output and skid entries
    always_comb begin
        out_valid_s  = out_valid_r;
        skid_valid_s = skid_valid_r;
        out_data_s   = out_data_r;
        skid_data_s  = skid_data_r;
        in_acc_s     = in_valid & ready_r;
        if (!out_valid_r || out_ready) begin
            // Output entry is free this cycle: refill from skid first, then input.
            if (skid_valid_r) begin
                out_data_s   = skid_data_r;
                out_valid_s  = 1'b1;
                skid_valid_s = 1'b0;
            end else if (in_acc_s) begin
                out_data_s  = in_data;
                out_valid_s = 1'b1;
            end else begin
                out_valid_s = 1'b0;
            end
        end else begin
            // Output stalled: an accepted beat parks in the skid entry.
            if (in_acc_s) begin
                skid_data_s  = in_data;
                skid_valid_s = 1'b1;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
        ready_s = ~skid_valid_s;
    end

    // Slice registers; ready stays low while in reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b0;
            out_data_r   <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
        end else begin
            out_valid_r  <= out_valid_s;
            skid_valid_r <= skid_valid_s;
            ready_r      <= ready_s;
            out_data_r   <= out_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
endmodule

// File: rtl/axis_length_split_pro.sv
// axis_length_split_pro: cuts AXI-Stream packets into fragments of at most
// `length` beats (0 = pass through), latching `length` at start of packet,
// and adds frag_first / pkt_last sideband. Output goes through axis_skid_slice.
// Optional macro SPLIT_FRAG_IDX_EN adds the fragment index output m_frag_idx.
module axis_length_split_pro
    import axis_split_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int KSIZE = DSIZE/8,
    parameter int USIZE = 1,
    parameter int LSIZE = 16
`ifdef SPLIT_FRAG_IDX_EN
    ,
    parameter int FSIZE = 8
`endif
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [LSIZE-1:0]        length,
    axis_length_split_pro_if.slave  s_axis,
    axis_length_split_pro_if.master m_axis,
    output logic                    m_frag_first,
    output logic                    m_pkt_last
`ifdef SPLIT_FRAG_IDX_EN
    ,
    output logic [FSIZE-1:0]        m_frag_idx
`endif
);
    typedef struct packed {
        logic [DSIZE-1:0] tdata;
        logic [KSIZE-1:0] tkeep;
        logic [USIZE-1:0] tuser;
        logic             tlast;
        logic             frag_first;
        logic             pkt_last;
`ifdef SPLIT_FRAG_IDX_EN
        logic [FSIZE-1:0] frag_idx;
`endif
    } split_beat_t;

    localparam int BW = $bits(split_beat_t);

    logic             sop_r;
    logic [LSIZE-1:0] len_r;
    logic [LSIZE-1:0] cnt_r;
    logic [LSIZE-1:0] eff_len_s;
    logic             boundary_s;
    logic             acc_s;
    logic             s_ready_s;
    logic             m_valid_s;
    split_beat_t      beat_s;
    split_beat_t      m_beat_s;
`ifdef SPLIT_FRAG_IDX_EN
    logic [FSIZE-1:0] fidx_r;
`endif

    assign acc_s        = s_axis.tvalid & s_ready_s;
    assign s_axis.tready = s_ready_s;

    // Effective length, fragment boundary and the pre-slice beat
    always_comb begin
        if (sop_r) begin
            eff_len_s = length;
        end else begin
            eff_len_s = len_r;
        end
        boundary_s = (eff_len_s != LSIZE'(LEN_PASS)) && (cnt_r == (eff_len_s - LSIZE'(1)));
        beat_s       = {BW{1'b0}};
        beat_s.tdata = s_axis.tdata;
        beat_s.tkeep = s_axis.tkeep;
        beat_s.tuser = s_axis.tuser;
        beat_s.tlast = s_axis.tlast | boundary_s;
        // In pass-through the counter wraps; that wrap is not a new fragment,
        // so only the start of packet counts as a fragment start there.
        beat_s.frag_first = (cnt_r == {LSIZE{1'b0}}) &&
                            (sop_r || (eff_len_s != LSIZE'(LEN_PASS)));
        beat_s.pkt_last = s_axis.tlast;
`ifdef SPLIT_FRAG_IDX_EN
        beat_s.frag_idx = fidx_r;
`endif
    end

    // Packet/fragment tracking: start-of-packet flag, latched length, beat counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sop_r <= 1'b1;
            len_r <= {LSIZE{1'b0}};
            cnt_r <= {LSIZE{1'b0}};
        end else if (acc_s) begin
            sop_r <= s_axis.tlast;
            if (sop_r) begin
                len_r <= length;
            end else begin
                len_r <= len_r;
            end
            if (s_axis.tlast || boundary_s) begin
                cnt_r <= {LSIZE{1'b0}};
            end else begin
                cnt_r <= cnt_r + LSIZE'(1);
            end
        end else begin
            sop_r <= sop_r;
            len_r <= len_r;
            cnt_r <= cnt_r;
        end
    end

`ifdef SPLIT_FRAG_IDX_EN
    // Fragment index within the packet, saturating at all-ones
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fidx_r <= {FSIZE{1'b0}};
        end else if (acc_s && s_axis.tlast) begin
            fidx_r <= {FSIZE{1'b0}};
        end else if (acc_s && boundary_s && (fidx_r != {FSIZE{1'b1}})) begin
            fidx_r <= fidx_r + FSIZE'(1);
        end else begin
            fidx_r <= fidx_r;
        end
    end
`endif

    axis_skid_slice #(.W(BW)) u_slice (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (s_axis.tvalid),
        .in_ready  (s_ready_s),
        .in_data   (beat_s),
        .out_valid (m_valid_s),
        .out_ready (m_axis.tready),
        .out_data  (m_beat_s)
    );

    assign m_axis.tvalid = m_valid_s;
    assign m_axis.tdata  = m_beat_s.tdata;
    assign m_axis.tkeep  = m_beat_s.tkeep;
    assign m_axis.tuser  = m_beat_s.tuser;
    assign m_axis.tlast  = m_beat_s.tlast;
    assign m_frag_first  = m_beat_s.frag_first;
    assign m_pkt_last    = m_beat_s.pkt_last;
`ifdef SPLIT_FRAG_IDX_EN
    assign m_frag_idx    = m_beat_s.frag_idx;
`endif
endmodule

// File: tb/tb_axis_length_split_pro.sv
// tb_axis_length_split_pro: scoreboard bench for the AXI-Stream length splitter.
// Runs with LSIZE=8 so the pass-through case exercises the counter wrap.
module tb_axis_length_split_pro;
    localparam int DSIZE = 32;
    localparam int KSIZE = 4;
    localparam int USIZE = 1;
    localparam int LSIZE = 8;
`ifdef SPLIT_FRAG_IDX_EN
    localparam int FSIZE = 8;
`endif

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [LSIZE-1:0] length;
    logic             m_frag_first;
    logic             m_pkt_last;
`ifdef SPLIT_FRAG_IDX_EN
    logic [7:0]       m_frag_idx;
`endif

    axis_length_split_pro_if #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)) s_if ();
    axis_length_split_pro_if #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)) m_if ();

    axis_length_split_pro #(
        .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .LSIZE(LSIZE)
`ifdef SPLIT_FRAG_IDX_EN
        , .FSIZE(FSIZE)
`endif
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .length       (length),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .m_frag_first (m_frag_first),
        .m_pkt_last   (m_pkt_last)
`ifdef SPLIT_FRAG_IDX_EN
        , .m_frag_idx (m_frag_idx)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [0:0]  u;
        logic        last;
        logic        first;
        logic        plast;
        logic [7:0]  idx;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cnt_last     = 0;
    int   cnt_first    = 0;
    int   stall_cnt    = 0;
    int   rdy_mode     = 0;   // 0: ready=1, 1: random, 2: ready=0

    // Reference model: expected sideband for beat i of an n-beat packet split by L.
    function automatic exp_t mk_exp(input logic [31:0] d, input logic [3:0] k,
                                    input logic u, input int i, input int n, input int L);
        exp_t e;
        int   pos;
        pos     = (L == 0) ? i : (i % L);
        e.d     = d;
        e.k     = k;
        e.u     = u;
        e.last  = ((L != 0) && (pos == L - 1)) || (i == n - 1);
        e.first = (L == 0) ? (i == 0) : (pos == 0);
        e.plast = (i == n - 1);
`ifdef SPLIT_FRAG_IDX_EN
        e.idx   = (L == 0) ? 8'd0 : (((i / L) > 255) ? 8'd255 : 8'(i / L));
`else
        e.idx   = 8'd0;
`endif
        return e;
    endfunction

    // Downstream ready generator, updated just after each rising edge.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom);
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Output monitor: in-order scoreboard and stability under backpressure.
    initial begin
        exp_t act;
        exp_t e;
        exp_t prev_pay;
        logic prev_stall;
        prev_stall = 1'b0;
        prev_pay   = '0;
        forever begin
            @(negedge aclk);
            act.d     = m_if.tdata;
            act.k     = m_if.tkeep;
            act.u     = m_if.tuser;
            act.last  = m_if.tlast;
            act.first = m_frag_first;
            act.plast = m_pkt_last;
`ifdef SPLIT_FRAG_IDX_EN
            act.idx   = m_frag_idx;
`else
            act.idx   = 8'd0;
`endif
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    tests_run++;
                    if (m_if.tvalid !== 1'b1 || act !== prev_pay) begin
                        tests_failed++;
                        $display("FAIL stable_under_stall: got valid=%b pay=%h, need valid=1 pay=%h",
                                 m_if.tvalid, act, prev_pay);
                    end
                end
                if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_beat: got %h, need no beat", act);
                    end else begin
                        e = sb_q.pop_front();
                        if (act !== e) begin
                            tests_failed++;
                            $display("FAIL beat: got d=%h k=%h u=%b last=%b first=%b plast=%b idx=%0d, need d=%h k=%h u=%b last=%b first=%b plast=%b idx=%0d",
                                     act.d, act.k, act.u, act.last, act.first, act.plast, act.idx,
                                     e.d, e.k, e.u, e.last, e.first, e.plast, e.idx);
                        end
                    end
                    if (act.last)  cnt_last++;
                    if (act.first) cnt_first++;
                end
                prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
                prev_pay   = act;
            end
        end
    end

    // Drive beats [start, min(n, stop_at)) of an n-beat packet, latched length len_a.
    task automatic send_pkt(input int n, input int len_a, input int chg_at, input int len_b,
                            input int start, input int stop_at, input int vprob);
        logic [31:0] d;
        logic [3:0]  k;
        logic        u;
        int          guard;
        length = len_a[LSIZE-1:0];
        for (int i = start; (i < n) && (i != stop_at); i++) begin
            @(negedge aclk);
            while ($urandom_range(99) >= vprob) begin
                s_if.tvalid = 1'b0;
                @(negedge aclk);
            end
            if (i == chg_at) length = len_b[LSIZE-1:0];
            d = $urandom;
            k = 4'($urandom);
            u = 1'($urandom);
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = k;
            s_if.tuser  = u;
            s_if.tlast  = (i == n - 1);
            guard = 0;
            while (s_if.tready !== 1'b1 && guard < 1000) begin
                stall_cnt++;
                @(negedge aclk);
                guard++;
            end
            if (s_if.tready !== 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL ready_timeout: got tready=%b after %0d cycles, need 1", s_if.tready, guard);
            end
            sb_q.push_back(mk_exp(d, k, u, i, n, len_a));
        end
        @(negedge aclk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (!(sb_q.size() == 0 && m_if.tvalid === 1'b0) && guard < 5000) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 5000) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: got %0d beats pending, need 0", sb_q.size());
        end
    endtask

    task automatic check_frags(input string name, input int exp_last, input int exp_first);
        tests_run++;
        if (cnt_last !== exp_last || cnt_first !== exp_first) begin
            tests_failed++;
            $display("FAIL %s_frag_count: got tlast=%0d first=%0d, need tlast=%0d first=%0d",
                     name, cnt_last, cnt_first, exp_last, exp_first);
        end
        cnt_last  = 0;
        cnt_first = 0;
    endtask

    task automatic test_reset();
        aresetn     = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'h0;
        s_if.tkeep  = 4'h0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        length      = 8'd0;
        #1 aresetn  = 1'b0;
        repeat (3) @(negedge aclk);
        tests_run++;
        if (m_if.tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b, need 0", m_if.tvalid); end
        tests_run++;
        if (s_if.tready !== 1'b0) begin tests_failed++; $display("FAIL reset_tready: got %b, need 0", s_if.tready); end
        tests_run++;
        if (m_if.tdata !== 32'h0 || m_if.tlast !== 1'b0 || m_frag_first !== 1'b0 || m_pkt_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_payload: got d=%h last=%b first=%b plast=%b, need all 0",
                     m_if.tdata, m_if.tlast, m_frag_first, m_pkt_last);
        end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        tests_run++;
        if (s_if.tready !== 1'b1) begin tests_failed++; $display("FAIL release_tready: got %b, need 1", s_if.tready); end
    endtask

    task automatic test_split_10();
        rdy_mode = 0;
        send_pkt(10, 4, -1, 4, 0, -1, 100);
        drain();
        check_frags("split10", 3, 3);
    endtask

    task automatic test_exact_8();
        send_pkt(8, 4, -1, 4, 0, -1, 100);
        drain();
        check_frags("exact8", 2, 2);
    endtask

    task automatic test_len_change();
        send_pkt(6, 4, 2, 2, 0, -1, 100);
        send_pkt(4, 2, -1, 2, 0, -1, 100);
        drain();
        check_frags("lenchg", 4, 4);
    endtask

    task automatic test_pass_through();
        send_pkt(300, 0, -1, 0, 0, -1, 100);
        drain();
        check_frags("pass", 1, 1);
    endtask

    task automatic test_back_to_back();
        rdy_mode = 1;
        send_pkt(7, 3, -1, 3, 0, -1, 60);
        send_pkt(9, 3, -1, 3, 0, -1, 60);
        send_pkt(1, 3, -1, 3, 0, -1, 60);
        send_pkt(5, 3, -1, 3, 0, -1, 60);
        drain();
        check_frags("random", 9, 9);
        rdy_mode = 0;
        repeat (3) @(negedge aclk);
        stall_cnt = 0;
        send_pkt(12, 3, -1, 3, 0, -1, 100);
        send_pkt(6, 3, -1, 3, 0, -1, 100);
        drain();
        tests_run++;
        if (stall_cnt !== 0) begin tests_failed++; $display("FAIL full_rate: got %0d stall cycles, need 0", stall_cnt); end
        check_frags("fullrate", 6, 6);
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        send_pkt(8, 4, -1, 4, 0, 2, 100);
        drain();
        rdy_mode = 2;
        repeat (2) @(negedge aclk);
        send_pkt(8, 4, -1, 4, 2, 3, 100);
        tests_run++;
        if (m_if.tvalid !== 1'b1) begin tests_failed++; $display("FAIL held_before_reset: got tvalid=%b, need 1", m_if.tvalid); end
        aresetn = 1'b0;
        #1;
        tests_run++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got tvalid=%b tready=%b, need 0 0", m_if.tvalid, s_if.tready);
        end
        sb_q.delete();
        cnt_last  = 0;
        cnt_first = 0;
        repeat (2) @(negedge aclk);
        aresetn  = 1'b1;
        rdy_mode = 0;
        send_pkt(4, 4, -1, 4, 0, -1, 100);
        drain();
        check_frags("after_reset", 1, 1);
    endtask

    initial begin
        test_reset();
        test_split_10();
        test_exact_8();
        test_len_change();
        test_pass_through();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL leftover: got %0d beats, need 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
